// File: rtl/spiker_step_sequencer.sv
// Timestep sequencer for the spiking core: launches STEPS core timesteps, waits for the
// core result and a free writer, strobes a sample, and reports done/error via sticky flags + irq.
module spiker_step_sequencer #(
   parameter int unsigned STEP_W         = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned TO_W           = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic              clear_i,
   input  logic [STEP_W-1:0] steps_i,
   output logic              core_start_o,
   input  logic              core_ready_i,
   input  logic              writer_ready_i,
   output logic              sample_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic              irq_o,
   output logic [STEP_W-1:0] step_cnt_o
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] LAUNCH    = 3'd1;
   localparam logic [2:0] WAIT_CORE = 3'd2;
   localparam logic [2:0] WAIT_WR   = 3'd3;
   localparam logic [2:0] SAMPLE    = 3'd4;

   localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
   localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);
   localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   logic [2:0]        state_q, state_d;
   logic [STEP_W-1:0] steps_q, steps_d;
   logic [STEP_W-1:0] cnt_q, cnt_d;
   logic [TO_W-1:0]   to_q, to_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              irq_q, irq_d;
   logic              core_start_q, core_start_d;
   logic              sample_q, sample_d;

   logic [STEP_W-1:0] cnt_inc;
   logic              to_hit;
   logic              wait_fail;

   assign cnt_inc = cnt_q + STEP_ONE;
   // This wait cycle is the TIMEOUT_CYCLES-th one spent in the current wait state.
   assign to_hit  = (to_q == TO_LAST);

   always_comb begin
      // NOTE: every next-state variable gets a default before the case so no latch is inferred.
      state_d   = state_q;
      steps_d   = steps_q;
      cnt_d     = cnt_q;
      to_d      = to_q;
      busy_d    = busy_q;
      done_d    = clear_i ? 1'b0 : done_q;
      err_d     = clear_i ? 1'b0 : err_q;
      irq_d     = 1'b0;
      wait_fail = 1'b0;

      if (abort_i && (state_q != IDLE)) begin
         state_d = IDLE;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i && !abort_i) begin
                  if (steps_i != '0) begin
                     steps_d = steps_i;
                     cnt_d   = '0;
                     done_d  = 1'b0;
                     err_d   = 1'b0;
                     busy_d  = 1'b1;
                     state_d = LAUNCH;
                  end else begin
                     err_d = 1'b1;
                     irq_d = 1'b1;
                  end
               end
            end
            LAUNCH: begin
               to_d    = '0;
               state_d = WAIT_CORE;
            end
            WAIT_CORE: begin
               if (core_ready_i) begin
                  to_d    = '0;
                  state_d = WAIT_WR;
               end else if (to_hit) begin
                  wait_fail = 1'b1;
               end else begin
                  to_d = to_q + TO_ONE;
               end
            end
            WAIT_WR: begin
               // to_q is zero only on the entry cycle, where writer_ready_i still shows the
               // writer's state from before it captured this result.
               if ((to_q != '0) && writer_ready_i) begin
                  state_d = SAMPLE;
               end else if (to_hit) begin
                  wait_fail = 1'b1;
               end else begin
                  to_d = to_q + TO_ONE;
               end
            end
            SAMPLE: begin
               cnt_d = cnt_inc;
               if (cnt_inc == steps_q) begin
                  done_d  = 1'b1;
                  irq_d   = 1'b1;
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  state_d = LAUNCH;
               end
            end
            default: begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         endcase

         if (wait_fail) begin
            err_d   = 1'b1;
            irq_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      end

      core_start_d = (state_d == LAUNCH);
      sample_d     = (state_d == SAMPLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         steps_q      <= '0;
         cnt_q        <= '0;
         to_q         <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         irq_q        <= 1'b0;
         core_start_q <= 1'b0;
         sample_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every flop updating from the same pre-edge values.
         state_q      <= state_d;
         steps_q      <= steps_d;
         cnt_q        <= cnt_d;
         to_q         <= to_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         irq_q        <= irq_d;
         core_start_q <= core_start_d;
         sample_q     <= sample_d;
      end
   end

   assign core_start_o = core_start_q;
   assign sample_o     = sample_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign irq_o        = irq_q;
   assign step_cnt_o   = cnt_q;

endmodule

// File: tb/tb_spiker_step_sequencer.sv
// Bench for spiker_step_sequencer: reactive core/writer models with random latencies and a
// run-level scoreboard predicting pulse counts, flags and step counts from the run parameters.
module tb_spiker_step_sequencer;

   localparam int TO_CYC = 1024;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       start_i, abort_i, clear_i;
   logic [3:0] steps_i;
   logic       core_start_o, core_ready_i, writer_ready_i, sample_o;
   logic       busy_o, done_o, err_o, irq_o;
   logic [3:0] step_cnt_o;

   int total = 0;
   int bad   = 0;

   // responder configuration and observed-event counters
   int core_lat   = 3;
   int wr_low     = 1;
   bit core_never = 1'b0;
   int n_start = 0, n_sample = 0, n_irq = 0, n_ready = 0;
   int cyc = 0, last_start_cyc = 0, irq_cyc = 0;
   int core_timer = 0, wr_delay = 0, wr_low_left = 0;
   bit dip_seen = 1'b0;

   spiker_step_sequencer dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .start_i       (start_i),
      .abort_i       (abort_i),
      .clear_i       (clear_i),
      .steps_i       (steps_i),
      .core_start_o  (core_start_o),
      .core_ready_i  (core_ready_i),
      .writer_ready_i(writer_ready_i),
      .sample_o      (sample_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .err_o         (err_o),
      .irq_o         (irq_o),
      .step_cnt_o    (step_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Core answers core_ready_i a fixed latency after each launch; the writer keeps its stale
   // ready high for one cycle after capturing, then drops it for wr_low cycles.
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         core_ready_i   = 1'b0;
         writer_ready_i = 1'b1;
         core_timer     = 0;
         wr_delay       = 0;
         wr_low_left    = 0;
         dip_seen       = 1'b0;
      end else begin
         cyc++;
         core_ready_i = 1'b0;
         if (core_timer > 0) begin
            core_timer--;
            if (core_timer == 0) begin
               core_ready_i = 1'b1;
               n_ready++;
               wr_delay = 2;
               dip_seen = 1'b0;
            end
         end
         if (core_start_o) begin
            n_start++;
            last_start_cyc = cyc;
            check("start_sample_excl", {31'd0, sample_o}, 32'd0);
            if (!core_never) core_timer = core_lat;
         end
         if (sample_o) begin
            n_sample++;
            check("sample_after_writer_dip", {31'd0, dip_seen}, 32'd1);
            dip_seen = 1'b0;
         end
         if (irq_o) begin
            n_irq++;
            irq_cyc = cyc;
         end
         if (wr_delay > 0) begin
            wr_delay--;
            if (wr_delay == 0) wr_low_left = wr_low;
         end
         if (wr_low_left > 0) begin
            writer_ready_i = 1'b0;
            wr_low_left--;
            dip_seen = 1'b1;
         end else begin
            writer_ready_i = 1'b1;
         end
      end
   end

   task automatic tick();
      @(negedge clk_i);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic start_run(input logic [3:0] s);
      steps_i = s;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_irq(input int budget, output bit ok);
      int base;
      base = n_irq;
      ok   = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         if (n_irq != base) ok = 1'b1;
      end
   endtask

   initial begin
      bit ok;
      int b_start, b_sample, b_irq, b_ready;
      logic [3:0] s;

      rst_ni = 1'b0;
      start_i = 1'b0; abort_i = 1'b0; clear_i = 1'b0; steps_i = 4'd0;
      core_ready_i = 1'b0; writer_ready_i = 1'b1;
      ticks(3);
      check("reset_outputs", {26'd0, busy_o, done_o, err_o, irq_o, core_start_o, sample_o},
            32'd0);
      check("reset_step_cnt", {28'd0, step_cnt_o}, 32'd0);
      rst_ni = 1'b1;
      ticks(2);

      // reference run: 3 steps, core answers 5 cycles after launch, writer busy 1 cycle
      core_lat = 5; wr_low = 1;
      b_start = n_start; b_sample = n_sample; b_irq = n_irq;
      start_run(4'd3);
      check("run3_busy", {31'd0, busy_o}, 32'd1);
      wait_irq(400, ok);
      check("run3_irq_seen", {31'd0, ok}, 32'd1);
      ticks(3);
      check("run3_starts", n_start - b_start, 32'd3);
      check("run3_samples", n_sample - b_sample, 32'd3);
      check("run3_irqs", n_irq - b_irq, 32'd1);
      check("run3_cnt", {28'd0, step_cnt_o}, 32'd3);
      check("run3_flags", {29'd0, busy_o, done_o, err_o}, 32'b010);

      // randomized complete runs, with ignored mid-run start and steps_i changes
      for (int r = 0; r < 8; r++) begin
         s = 4'($urandom_range(1, 15));
         core_lat = $urandom_range(1, 8);
         wr_low   = $urandom_range(1, 4);
         b_start = n_start; b_sample = n_sample; b_irq = n_irq;
         start_run(s);
         tick();
         steps_i = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) begin
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
         end
         wait_irq(s * 40 + 40, ok);
         check("rnd_irq_seen", {31'd0, ok}, 32'd1);
         ticks(3);
         check("rnd_starts", n_start - b_start, {28'd0, s});
         check("rnd_samples", n_sample - b_sample, {28'd0, s});
         check("rnd_irqs", n_irq - b_irq, 32'd1);
         check("rnd_cnt", {28'd0, step_cnt_o}, {28'd0, s});
         check("rnd_flags", {29'd0, busy_o, done_o, err_o}, 32'b010);
      end

      // clear drops done; clear together with an error event leaves err set
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      check("clear_done", {30'd0, done_o, err_o}, 32'b00);
      clear_i = 1'b1;
      b_start = n_start;
      start_run(4'd0);
      clear_i = 1'b0;
      check("zero_steps_err_wins", {28'd0, busy_o, err_o, irq_o, done_o}, 32'b0110);
      tick();
      check("zero_steps_irq_single", {31'd0, irq_o}, 32'd0);
      ticks(3);
      check("zero_steps_no_launch", n_start - b_start, 32'd0);

      // timeout waiting for a core that never answers
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      core_never = 1'b1;
      b_sample = n_sample;
      start_run(4'd15);
      wait_irq(TO_CYC + 100, ok);
      check("timeout_irq_seen", {31'd0, ok}, 32'd1);
      check("timeout_latency", irq_cyc - last_start_cyc, 32'(TO_CYC + 1));
      tick();
      check("timeout_flags", {29'd0, busy_o, done_o, err_o}, 32'b001);
      check("timeout_cnt", {28'd0, step_cnt_o}, 32'd0);
      check("timeout_no_sample", n_sample - b_sample, 32'd0);
      core_never = 1'b0;

      // abort during the writer wait of step 2
      core_lat = 2; wr_low = 8;
      b_start = n_start; b_sample = n_sample; b_irq = n_irq; b_ready = n_ready;
      start_run(4'd4);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         tick();
         if (n_ready - b_ready >= 2) ok = 1'b1;
      end
      check("abort_reached_step2", {31'd0, ok}, 32'd1);
      ticks(2);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      check("abort_state", {28'd0, busy_o, done_o, err_o, irq_o}, 32'b0000);
      check("abort_cnt", {28'd0, step_cnt_o}, 32'd1);
      ticks(15);
      check("abort_no_irq", n_irq - b_irq, 32'd0);
      check("abort_samples", n_sample - b_sample, 32'd1);
      check("abort_starts", n_start - b_start, 32'd2);

      // start together with abort: mid-run aborts, in idle nothing happens
      core_lat = 3; wr_low = 1;
      b_start = n_start; b_irq = n_irq;
      start_run(4'd3);
      ticks(3);
      steps_i = 4'd7;
      start_i = 1'b1; abort_i = 1'b1;
      tick();
      start_i = 1'b0; abort_i = 1'b0;
      check("start_abort_busy", {31'd0, busy_o}, 32'd0);
      ticks(10);
      check("start_abort_stays_idle", {31'd0, busy_o}, 32'd0);
      check("start_abort_starts", n_start - b_start, 32'd1);
      check("start_abort_no_irq", n_irq - b_irq, 32'd0);
      steps_i = 4'd5;
      start_i = 1'b1; abort_i = 1'b1;
      tick();
      start_i = 1'b0; abort_i = 1'b0;
      ticks(3);
      check("idle_start_abort", {29'd0, busy_o, err_o, irq_o}, 32'd0);

      // reset during the sample of step 2, then a clean 1-step run
      b_sample = n_sample;
      start_run(4'd4);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         tick();
         if (n_sample - b_sample >= 2) ok = 1'b1;
      end
      check("rst_reached_sample2", {31'd0, ok}, 32'd1);
      rst_ni = 1'b0;
      #1;
      check("rst_mid_outputs", {25'd0, busy_o, done_o, err_o, irq_o, core_start_o, sample_o,
            (step_cnt_o != 4'd0)}, 32'd0);
      ticks(2);
      rst_ni = 1'b1;
      b_sample = n_sample; b_irq = n_irq; b_start = n_start;
      ticks(10);
      check("rst_no_trailing", (n_sample - b_sample) + (n_irq - b_irq), 32'd0);
      start_run(4'd1);
      wait_irq(100, ok);
      check("rst_rerun_irq", {31'd0, ok}, 32'd1);
      tick();
      check("rst_rerun_cnt", {28'd0, step_cnt_o}, 32'd1);
      check("rst_rerun_flags", {29'd0, busy_o, done_o, err_o}, 32'b010);
      check("rst_rerun_pulses", (n_start - b_start) * 16 + (n_sample - b_sample), 32'h11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spiker_step_sequencer.md
SPIKER_STEP_SEQUENCER -- requirements
Module: spiker_step_sequencer

Interface
REQ-001 SHALL provide parameters, one per line:
- STEP_W, 4, width of step count/config
- TIMEOUT_CYCLES, 1024, max wait cycles per handshake phase
- TO_W, 16, timeout counter width
REQ-002 SHALL provide ports, one per line:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  software start pulse (from reg file)
- abort_i  in  1  software abort pulse
- clear_i  in  1  clears done_o/err_o
- steps_i  in  STEP_W  number of timesteps per run, valid 1..2^STEP_W-1
- core_start_o  out  1  one-cycle timestep launch to spiking core
- core_ready_i  in  1  core result valid (same signal fed to writer ready_i)
- writer_ready_i  in  1  writer pipeline free (writer_ready_o of writer)
- sample_o  out  1  one-cycle sample strobe to writer
- busy_o  out  1  run in progress
- done_o  out  1  sticky run-complete flag
- err_o  out  1  sticky error flag (timeout or steps_i=0)
- irq_o  out  1  one-cycle pulse on done or error
- step_cnt_o  out  STEP_W  completed timesteps in current/last run

Function
REQ-003 SHALL implement FSM states IDLE, LAUNCH, WAIT_CORE, WAIT_WR, SAMPLE.
REQ-004 IDLE + start_i with steps_i != 0: latch steps_i, step_cnt_o <= 0, done_o <= 0, err_o <= 0, busy_o <= 1, go LAUNCH.
REQ-005 IDLE + start_i with steps_i == 0: err_o <= 1, irq_o pulse, stay IDLE, busy_o stays 0.
REQ-006 LAUNCH: core_start_o = 1 for exactly this cycle (registered output), timeout counter cleared, go WAIT_CORE.
REQ-007 WAIT_CORE: on core_ready_i = 1 go WAIT_WR and clear timeout counter; else increment counter.
REQ-008 WAIT_WR: on writer_ready_i = 1 go SAMPLE; else increment counter. Entry cycle SHALL NOT sample writer_ready_i (writer deasserts it one cycle after capture).
REQ-009 SAMPLE: sample_o = 1 for exactly one cycle, step_cnt_o <= step_cnt_o + 1; if new count == latched steps go IDLE with done_o <= 1, irq_o pulse, busy_o <= 0; else go LAUNCH.
REQ-010 Timeout: counter reaching TIMEOUT_CYCLES in WAIT_CORE or WAIT_WR SHALL set err_o, pulse irq_o, clear busy_o, return IDLE, with no sample_o; step_cnt_o held.
REQ-011 abort_i in any non-IDLE state SHALL return IDLE next cycle, busy_o <= 0, no core_start_o/sample_o issued, no irq_o, step_cnt_o held; abort_i in IDLE no effect.
REQ-012 Simultaneous abort_i and start_i: abort wins; start ignored.
REQ-013 start_i while busy_o = 1 SHALL be ignored; steps_i changes mid-run SHALL NOT affect the run.
REQ-014 clear_i SHALL clear done_o and err_o; if coincident with a set event, set wins.
REQ-015 core_ready_i outside WAIT_CORE SHALL be ignored.
REQ-016 All outputs SHALL be registered; core_start_o and sample_o never both high.
REQ-017 step_cnt_o SHALL never wrap (max value = latched steps ≤ 2^STEP_W-1).

Reset
REQ-018 Reset SHALL force IDLE; busy_o, done_o, err_o, irq_o, core_start_o, sample_o = 0; step_cnt_o = 0; timeout counter = 0.
REQ-019 Reset asserted mid-run SHALL abort immediately with no trailing sample_o or irq_o after release.

Verification
REQ-020 steps_i=3, core_ready_i 5 cycles after each core_start_o, writer_ready_i low 1 cycle after -> 3 core_start_o, 3 sample_o, step_cnt_o=3, done_o=1, one irq_o.
REQ-021 steps_i=0 + start_i -> err_o=1, irq_o one pulse, no core_start_o, busy_o=0.
REQ-022 steps_i=15, core_ready_i never asserted -> err_o=1 after TIMEOUT_CYCLES in WAIT_CORE, step_cnt_o=0, no sample_o.
REQ-023 steps_i=4, abort_i during WAIT_WR of step 2 -> busy_o=0 next cycle, step_cnt_o=1, done_o=0, no irq_o.
REQ-024 start_i asserted during run and together with abort_i -> ignored; run count unchanged / aborted respectively.
REQ-025 rst_ni low during SAMPLE of step 2 -> all outputs 0; new start_i steps_i=1 completes normally.
